fp_normalizer_pipe: RTL and testbench

Parametrised, pipelined post-normalizer for the FP multiply/divide datapath. It sits between the mantissa multiplier/divider and the rounding/packing stage.
- Finds the leading one anywhere in the raw mantissa, not just the top two bits.
- Shifts the mantissa, adjusts the exponent and collapses dropped bits into a sticky bit.
- Saturates on overflow and underflow.
- Uses a valid/ready handshake with a global enable.

---
 rtl/fp_norm_pkg.sv | 33 +++
 rtl/fp_normalizer_pipe_lzc.sv | 41 ++++
 rtl/fp_normalizer_pipe.sv | 152 +++++++++++++++
 tb/tb_fp_normalizer_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared widths, the S1 pipeline register format and the exponent adjustment
// used by the FP post-normalizer.
package fp_norm_pkg;

  localparam int MANT_IN_W_DEF  = 48;
  localparam int MANT_OUT_W_DEF = 26;
  localparam int EXP_IN_W_DEF   = 10;
  localparam int EXP_OUT_W_DEF  = 8;
  localparam int LZC_W_DEF      = $clog2(MANT_IN_W_DEF + 1);
  localparam int EXP_ADJ_W      = EXP_IN_W_DEF + 2;

  localparam logic [EXP_OUT_W_DEF-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic [MANT_IN_W_DEF-1:0] mant;
    logic [EXP_IN_W_DEF-1:0]  exp;
    logic [LZC_W_DEF-1:0]     lzc;
    logic                     sel;
    logic                     valid;
  } s1_t;

  // Multiply results carry two integer bits, so they gain one exponent step.
  function automatic logic signed [EXP_ADJ_W-1:0] adjustExp(
    input logic [EXP_IN_W_DEF-1:0] expIn,
    input logic                    selIn,
    input logic [LZC_W_DEF-1:0]    lzc
  );
    logic signed [EXP_ADJ_W-1:0] ext;
    ext = {{2{expIn[EXP_IN_W_DEF-1]}}, expIn};
    return ext + (selIn ? EXP_ADJ_W'(0) : EXP_ADJ_W'(1)) - EXP_ADJ_W'(lzc);
  endfunction

endpackage

// File: rtl/fp_normalizer_pipe_lzc.sv
// Parametrised combinational leading-zero counter built as a binary tree;
// an all-zero input reports a count equal to the input width.
module fp_lzc #(
  parameter int W     = 48,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int LEVELS = $clog2(W);
  localparam int P      = 1 << LEVELS;

  // Padding with ones below the data caps the count at W for a zero input.
  logic [P-1:0] padded;

  always_comb begin
    padded = '1;
    padded[P-1 -: W] = data_i;
  end

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [l:0] node [P >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_bit
        assign node[i] = ~padded[i];
      end
    end else begin : g_merge
      for (genvar j = 0; j < (P >> l); j++) begin : g_pair
        logic [l-1:0] hi;
        logic [l-1:0] lo;
        assign hi = g_lvl[l-1].node[2*j+1];
        assign lo = g_lvl[l-1].node[2*j];
        assign node[j] = hi[l-1] ? ({1'b0, hi} + {1'b0, lo}) : {1'b0, hi};
      end
    end
  end

  assign count_o = CNT_W'(g_lvl[LEVELS].node[0]);

endmodule

// File: rtl/fp_normalizer_pipe.sv
// Two-stage post-normalizer for the FP mul/div datapath with valid/ready flow
// control. Define SUBNORMAL_EN to denormalize on underflow instead of flushing.
module fp_normalizer_pipe
  import fp_norm_pkg::*;
#(
  parameter int MANT_IN_W  = MANT_IN_W_DEF,
  parameter int MANT_OUT_W = MANT_OUT_W_DEF,
  parameter int EXP_IN_W   = EXP_IN_W_DEF,
  parameter int EXP_OUT_W  = EXP_OUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  en,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [MANT_IN_W-1:0]  mantisa_mul,
  input  logic [EXP_IN_W-1:0]   exponent_add,
  input  logic                  sel,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [MANT_OUT_W-1:0] mantisa_normalize,
  output logic [EXP_OUT_W-1:0]  exponent_simple,
  output logic                  ovf,
  output logic                  unf,
  output logic                  zero
);

  localparam int LZC_W = $clog2(MANT_IN_W + 1);
  localparam int EW    = EXP_IN_W + 2;

  localparam logic [LZC_W-1:0]     LZC_ZERO = LZC_W'(MANT_IN_W);
  localparam logic signed [EW-1:0] OVF_LIM  = EW'((1 << EXP_OUT_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic [LZC_W-1:0] lzc;
  s1_t              s1_q;

  logic                  v2_q;
  logic [MANT_OUT_W-1:0] mant_q, mant_d;
  logic [EXP_OUT_W-1:0]  exp_q, exp_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  zero_q, zero_d;

  logic adv1, adv2;

  logic [MANT_IN_W-1:0]  shifted;
  logic [MANT_OUT_W-1:0] normMant;
  logic signed [EW-1:0]  expAdj;

  fp_lzc #(.W(MANT_IN_W)) u_lzc (
    .data_i  (mantisa_mul),
    .count_o (lzc)
  );

  assign adv2      = !v2_q | ready_in;
  assign adv1      = !s1_q.valid | adv2;
  assign ready_out = en & adv1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_q <= '0;
    end else if (ready_out) begin
      s1_q.valid <= valid_in;
      if (valid_in) begin
        s1_q.mant <= mantisa_mul;
        s1_q.exp  <= exponent_add;
        s1_q.lzc  <= lzc;
        s1_q.sel  <= sel;
      end
    end
  end

  // Bits below the kept window collapse into the sticky LSB.
  always_comb begin
    shifted  = s1_q.mant << s1_q.lzc;
    normMant = {shifted[MANT_IN_W-1 -: MANT_OUT_W-1], |shifted[MANT_IN_W-MANT_OUT_W:0]};
    expAdj   = adjustExp(s1_q.exp, s1_q.sel, s1_q.lzc);
  end

`ifdef SUBNORMAL_EN
  logic signed [EW-1:0]  denormShift;
  logic [MANT_OUT_W-1:0] lostMask;
  logic [MANT_OUT_W-1:0] subMant;

  localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
  localparam logic signed [EW-1:0] SHIFT_LIM = EW'(MANT_OUT_W);

  always_comb begin
    denormShift = EXP_ONE - expAdj;
    lostMask    = ~({MANT_OUT_W{1'b1}} << denormShift);
    subMant     = normMant >> denormShift;
    subMant[0]  = subMant[0] | (|(normMant & lostMask));
    if (denormShift >= SHIFT_LIM) begin
      subMant = {{(MANT_OUT_W-1){1'b0}}, |shifted};
    end
  end
`endif

  always_comb begin
    mant_d = normMant;
    exp_d  = expAdj[EXP_OUT_W-1:0];
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    if (s1_q.lzc == LZC_ZERO) begin
      zero_d = 1'b1;
      mant_d = '0;
      exp_d  = '0;
    end else if (expAdj >= OVF_LIM) begin
      ovf_d  = 1'b1;
      mant_d = '0;
      exp_d  = EXP_ONES;
    end else if (expAdj <= EXP_ZERO) begin
      unf_d  = 1'b1;
      exp_d  = '0;
`ifdef SUBNORMAL_EN
      mant_d = subMant;
`else
      mant_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v2_q   <= 1'b0;
      mant_q <= '0;
      exp_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (en & adv2) begin
      v2_q <= s1_q.valid;
      if (s1_q.valid) begin
        mant_q <= mant_d;
        exp_q  <= exp_d;
        ovf_q  <= ovf_d;
        unf_q  <= unf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign valid_out         = v2_q;
  assign mantisa_normalize = mant_q;
  assign exponent_simple   = exp_q;
  assign ovf               = ovf_q;
  assign unf               = unf_q;
  assign zero              = zero_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// Scoreboard bench for fp_normalizer_pipe: a reference model predicts every
// accepted beat and the monitor compares each beat the DUT hands downstream.
module tb_fp_normalizer_pipe;

  logic        clk = 1'b0;
  logic        arst;
  logic        en;
  logic        valid_in;
  logic        ready_out;
  logic [47:0] mantisa_mul;
  logic [9:0]  exponent_add;
  logic        sel;
  logic        valid_out;
  logic        ready_in;
  logic [25:0] mantisa_normalize;
  logic [7:0]  exponent_simple;
  logic        ovf, unf, zero;

  typedef struct packed {
    logic [25:0] mant;
    logic [7:0]  exp;
    logic        ovf;
    logic        unf;
    logic        zero;
  } expect_t;

  expect_t sbQ[$];
  int checks   = 0;
  int failures = 0;

  fp_normalizer_pipe dut (
    .clk               (clk),
    .arst              (arst),
    .en                (en),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .mantisa_mul       (mantisa_mul),
    .exponent_add      (exponent_add),
    .sel               (sel),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .mantisa_normalize (mantisa_normalize),
    .exponent_simple   (exponent_simple),
    .ovf               (ovf),
    .unf               (unf),
    .zero              (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: bit-scan for the leading one, then saturate/denormalize.
  function automatic expect_t modelNorm(input logic [47:0] m, input logic [9:0] x, input logic s);
    expect_t     r;
    int          lz;
    int          e;
    logic [47:0] sh;
    logic [25:0] mn;
    r = '0;
    if (m == 48'd0) begin
      r.zero = 1'b1;
      return r;
    end
    lz = 0;
    while (m[47-lz] == 1'b0) lz++;
    e  = int'($signed(x)) + (s ? 0 : 1) - lz;
    sh = m << lz;
    mn = {sh[47:23], |sh[22:0]};
    if (e >= 255) begin
      r.ovf = 1'b1;
      r.exp = 8'hFF;
    end else if (e <= 0) begin
      r.unf = 1'b1;
`ifdef SUBNORMAL_EN
      if (1 - e >= 26) begin
        r.mant = 26'd1;
      end else begin
        logic lost;
        lost = 1'b0;
        for (int k = 0; k < 1 - e; k++) lost = lost | mn[k];
        r.mant    = mn >> (1 - e);
        r.mant[0] = r.mant[0] | lost;
      end
`endif
    end else begin
      r.mant = mn;
      r.exp  = 8'(e);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!arst && en && valid_out && ready_in) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedBeat", valid_out, 1'b0);
      end else begin
        expect_t exp_v;
        exp_v = sbQ.pop_front();
        checkOutput("mant", mantisa_normalize, exp_v.mant);
        checkOutput("exp", exponent_simple, exp_v.exp);
        checkOutput("flags", {ovf, unf, zero}, {exp_v.ovf, exp_v.unf, exp_v.zero});
      end
    end
  end

  // Offer one beat until accepted; leaves valid_in high for back-to-back use.
  task automatic applyStimulus(input logic [47:0] m, input logic [9:0] x, input logic s);
    logic accepted;
    accepted     = 1'b0;
    mantisa_mul  = m;
    exponent_add = x;
    sel          = s;
    valid_in     = 1'b1;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (ready_out) begin
        sbQ.push_back(modelNorm(m, x, s));
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("acceptTimeout", accepted, 1'b1);
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 100 && sbQ.size() != 0; c++) @(posedge clk);
    #1;
    checkOutput("drain", sbQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [47:0] bpM [3];
    int          acc;
    bpM[0] = 48'h8000_0000_0000;
    bpM[1] = 48'h4000_0000_0001;
    bpM[2] = 48'h0F00_0000_0000;

    arst = 1'b1; en = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    mantisa_mul = '0; exponent_add = '0; sel = 1'b0;
    #2;
    checkOutput("rstValid", valid_out, 1'b0);
    checkOutput("rstMant", mantisa_normalize, 26'd0);
    checkOutput("rstExp", exponent_simple, 8'd0);
    checkOutput("rstFlags", {ovf, unf, zero}, 3'b000);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("readyIdle", ready_out, 1'b1);

    $display("[TB] latency and directed beats");
    applyStimulus(48'h8000_0000_0000, 10'd130, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("lat1", valid_out, 1'b0);
    @(negedge clk);
    checkOutput("lat2", valid_out, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(48'h4000_0000_0001, 10'd130, 1'b1);
    applyStimulus(48'h8000_0000_0000, 10'd254, 1'b0);
    applyStimulus(48'h0000_0000_0001, 10'd20,  1'b0);
    applyStimulus(48'h0000_0000_0000, 10'd77,  1'b0);
    applyStimulus(48'h8000_0000_0000, 10'd253, 1'b0);
    applyStimulus(48'h8000_0000_0000, 10'd0,   1'b0);
    applyStimulus(48'h8000_0000_0000, 10'd0,   1'b1);
    applyStimulus(48'hC000_0000_0003, 10'h3FE, 1'b1);
    applyStimulus(48'h0000_0000_0001, 10'd100, 1'b1);
    applyStimulus(48'hFFFF_FFFF_FFFF, 10'd300, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(48'({$urandom(), $urandom()}) >> $urandom_range(0, 47),
                    (i % 2 == 0) ? 10'($urandom_range(0, 300)) : 10'($urandom()),
                    1'($urandom()));
    end
    valid_in = 1'b0;
    waitDrain();

    $display("[TB] backpressure");
    ready_in = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      mantisa_mul  = bpM[(acc < 3) ? acc : 2];
      exponent_add = 10'd140;
      sel          = 1'b0;
      valid_in     = 1'b1;
      @(negedge clk);
      if (ready_out && acc < 3) begin
        sbQ.push_back(modelNorm(mantisa_mul, exponent_add, sel));
        acc++;
      end
      if (c >= 2) begin
        checkOutput("bpReady", ready_out, 1'b0);
        checkOutput("bpValid", valid_out, 1'b1);
        if (sbQ.size() > 0) checkOutput("bpHold", mantisa_normalize, sbQ[0].mant);
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bpAccepted", acc, 2);
    valid_in = 1'b0;
    ready_in = 1'b1;
    waitDrain();

    $display("[TB] enable freeze");
    applyStimulus(48'h1234_5678_9ABC, 10'd90, 1'b1);
    applyStimulus(48'h0000_8000_0001, 10'd60, 1'b0);
    en = 1'b0;
    mantisa_mul = 48'hAAAA_0000_5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("enReady", ready_out, 1'b0);
      checkOutput("enValid", valid_out, 1'b1);
      if (sbQ.size() > 0) begin
        checkOutput("enMant", mantisa_normalize, sbQ[0].mant);
        checkOutput("enExp", exponent_simple, sbQ[0].exp);
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    en = 1'b1;
    waitDrain();

    $display("[TB] reset mid-flight");
    applyStimulus(48'h8000_0000_0000, 10'd50, 1'b0);
    applyStimulus(48'h4000_0000_0000, 10'd60, 1'b1);
    valid_in = 1'b0;
    #1;
    arst = 1'b1;
    #1;
    checkOutput("midRstValid", valid_out, 1'b0);
    checkOutput("midRstMant", mantisa_normalize, 26'd0);
    checkOutput("midRstExp", exponent_simple, 8'd0);
    checkOutput("midRstFlags", {ovf, unf, zero}, 3'b000);
    sbQ.delete();
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(48'h0003_0000_0000, 10'd200, 1'b0);
    valid_in = 1'b0;
    @(negedge clk);
    checkOutput("rstLat1", valid_out, 1'b0);
    @(negedge clk);
    checkOutput("rstLat2", valid_out, 1'b1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
